// File: rtl/wb_bram_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared Wishbone cycle/burst types and burst index stepping.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLASSIC = 2'd1,
    ST_BURST   = 2'd2
  } state_t;

  // Wrap modes step only the low bits; the result is folded to the word-index width.
  function automatic logic [31:0] next_index(input logic [31:0] index, input bte_t bte,
                                             input int unsigned width);
    logic [31:0] n;
    logic [31:0] mask;
    case (bte)
      BTE_WRAP4:  n = {index[31:2], index[1:0] + 2'd1};
      BTE_WRAP8:  n = {index[31:3], index[2:0] + 3'd1};
      BTE_WRAP16: n = {index[31:4], index[3:0] + 4'd1};
      default:    n = index + 32'd1;
    endcase
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return n & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_burst_adr_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_adr_gen
// Description : Registered burst word index with one-beat-ahead prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_adr_gen
  import wb_pkg::*;
#(
  parameter int MEM_ADR_W = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 incr,
  input  bte_t                 bte,
  input  logic [MEM_ADR_W-1:0] start_idx,
  output logic [MEM_ADR_W-1:0] rd_idx
);

  logic [MEM_ADR_W-1:0] r_idx;
  logic                 r_incr;
  bte_t                 r_bte;

  // The word read on this edge: the request address at burst start, else the prefetch.
  assign rd_idx = load ? start_idx : r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_incr <= 1'b0;
      r_bte  <= BTE_LINEAR;
    end else if (load) begin
      r_incr <= incr;
      r_bte  <= bte;
      r_idx  <= incr ? MEM_ADR_W'(next_index(32'(start_idx), bte, MEM_ADR_W)) : start_idx;
    end else if (advance && r_incr) begin
      r_idx  <= MEM_ADR_W'(next_index(32'(r_idx), r_bte, MEM_ADR_W));
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_burst
// Description : Wishbone B4 registered-feedback BlockRAM slave with bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bram_burst
  import wb_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADR_W     = 32,
  parameter int    MEM_ADR_W = 11,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cyc,
  input  logic                stb,
  input  logic                we,
  input  logic [ADR_W-1:0]    adr,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [2:0]          cti,
  input  logic [1:0]          bte,
  input  logic [DATA_W-1:0]   dat_ms,
  output logic [DATA_W-1:0]   dat_sm,
  output logic                ack,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int BL    = $clog2(NB);
  localparam int DEPTH = 1 << MEM_ADR_W;

  logic [DATA_W-1:0]    mem [DEPTH];
  state_t               r_state;
  logic                 r_we;
  logic                 w_req;
  logic                 w_in_range;
  logic                 w_burst_cti;
  logic                 w_start;
  logic                 w_bad;
  logic                 w_continue;
  logic                 w_wr;
  logic [MEM_ADR_W-1:0] w_idx;
  logic [MEM_ADR_W-1:0] w_rd_idx;

  generate
    if (BL > 0) begin : g_lo_adr
      logic w_unused_lo;
      assign w_unused_lo = ^adr[BL-1:0];
    end
  endgenerate

  assign w_req       = cyc & stb;
  assign w_idx       = adr[MEM_ADR_W+BL-1:BL];
  assign w_in_range  = (adr[ADR_W-1:MEM_ADR_W+BL] == '0);
  assign w_burst_cti = (cti == CTI_CONST) || (cti == CTI_INCR);
  // A request seen while err is showing is the one just errored; ignore it.
  assign w_start     = (r_state == ST_IDLE) && w_req && w_in_range && !err;
  assign w_bad       = (r_state == ST_IDLE) && w_req && !w_in_range && !err;
  assign w_continue  = (r_state == ST_BURST) && w_req && (we == r_we) && (cti != CTI_EOB);
  assign w_wr        = w_req && we && ack;

  wb_burst_adr_gen #(
    .MEM_ADR_W (MEM_ADR_W)
  ) u_adr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (w_start),
    .advance   (w_continue),
    .incr      (cti == CTI_INCR),
    .bte       (bte_t'(bte)),
    .start_idx (w_idx),
    .rd_idx    (w_rd_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      dat_sm  <= '0;
    end else begin
      err <= w_bad;
      ack <= w_start || w_continue;
      if (w_start || w_continue) dat_sm <= mem[w_rd_idx];
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_we    <= we;
            r_state <= w_burst_cti ? ST_BURST : ST_CLASSIC;
          end
        end
        ST_CLASSIC: r_state <= ST_IDLE;
        ST_BURST:   if (!w_continue) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Writes always use the master's current address, one beat per acked edge.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (sel[i]) mem[w_idx][8*i +: 8] <= dat_ms[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bram_burst
// Description : Self-checking bench for wb_bram_burst (vectors + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bram_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, ack, err;
  logic [31:0] adr, dat_ms, dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [2048];
  logic [31:0] sb_q [$];

  typedef struct {
    bit          wr;
    int          idx;
    logic [3:0]  s;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  wb_bram_burst dut (
    .clk    (clk),
    .rst    (rst),
    .cyc    (cyc),
    .stb    (stb),
    .we     (we),
    .adr    (adr),
    .sel    (sel),
    .cti    (cti),
    .bte    (bte),
    .dat_ms (dat_ms),
    .dat_sm (dat_sm),
    .ack    (ack),
    .err    (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input string name);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h with empty scoreboard", name, dat_sm);
    end else begin
      e = sb_q.pop_front();
      chk(name, dat_sm, e);
    end
  endtask

  function automatic int nxt(input int idx, input logic [1:0] b);
    int n;
    n = (b == 2'd0) ? 2048 : (b == 2'd1) ? 4 : (b == 2'd2) ? 8 : 16;
    return (idx - (idx % n)) + ((idx + 1) % n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; cti = 0; bte = 0; dat_ms = 0;
  endtask

  task automatic classic(input bit w, input int idx, input logic [3:0] s,
                         input logic [31:0] d, input string name);
    int lat;
    cyc = 1; stb = 1; we = w; adr = 32'(idx) << 2; sel = s; dat_ms = d;
    cti = 3'b000; bte = 2'b00;
    lat = 0;
    do begin step(); lat++; end while (!ack && !err && lat < 8);
    chk({name, " latency"}, 32'(lat), 32'd1);
    chk({name, " err"}, {31'b0, err}, 32'd0);
    if (!w) sb_pop({name, " data"});
    else for (int i = 0; i < 4; i++) if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    step();
    chk({name, " ack drop"}, {31'b0, ack}, 32'd0);
    idle_bus();
  endtask

  task automatic burst(input bit w, input logic [2:0] kind, input logic [1:0] b,
                       input int start, input int n, input string name);
    int idx, lat;
    logic [31:0] d;
    idx = start;
    if (!w) begin
      for (int k = 0; k < n; k++) begin
        sb_q.push_back(model[idx]);
        if (kind == 3'b010) idx = nxt(idx, b);
      end
      idx = start;
    end
    d = $urandom;
    cyc = 1; stb = 1; we = w; sel = 4'hF; bte = b; cti = kind;
    adr = 32'(idx) << 2; dat_ms = d;
    lat = 0;
    do begin step(); lat++; end while (!ack && !err && lat < 8);
    chk({name, " latency"}, 32'(lat), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        step();
        d = $urandom;
      end
      adr = 32'(idx) << 2;
      cti = (k == n - 1) ? 3'b111 : kind;
      chk($sformatf("%s beat%0d ack", name, k), {31'b0, ack}, 32'd1);
      if (w) begin
        dat_ms = d;
        model[idx] = d;
      end else begin
        sb_pop($sformatf("%s beat%0d data", name, k));
      end
      if (kind == 3'b010) idx = nxt(idx, b);
    end
    step();
    chk({name, " ack drop"}, {31'b0, ack}, 32'd0);
    idle_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 4,    4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 4,    4'hF, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1, 5,    4'hF, 32'h11223344, 32'h0};
    tbl[3]  = '{1, 5,    4'h1, 32'h000000AA, 32'h0};
    tbl[4]  = '{0, 5,    4'hF, 32'h0,        32'h112233AA};
    tbl[5]  = '{1, 7,    4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{1, 7,    4'h6, 32'h12345678, 32'h0};
    tbl[7]  = '{0, 7,    4'hF, 32'h0,        32'hFF3456FF};
    tbl[8]  = '{1, 2047, 4'hF, 32'h01020304, 32'h0};
    tbl[9]  = '{1, 2047, 4'h8, 32'hAB000000, 32'h0};
    tbl[10] = '{0, 2047, 4'hF, 32'h0,        32'hAB020304};

    idle_bus();
    rst = 0;
    repeat (3) step();
    chk("reset ack", {31'b0, ack}, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset dat_sm", dat_sm, 32'd0);
    rst = 1;
    step();

    burst(1, 3'b010, 2'b00, 2040, 8, "fill_hi");
    burst(1, 3'b010, 2'b00, 0, 32, "fill_lo");

    for (int i = 0; i < 11; i++) begin
      if (!tbl[i].wr) sb_q.push_back(tbl[i].exp);
      classic(tbl[i].wr, tbl[i].idx, tbl[i].s, tbl[i].wdat, $sformatf("vec%0d", i));
    end

    burst(0, 3'b010, 2'b00, 2047, 3, "incr_lin");
    burst(0, 3'b010, 2'b01, 6, 4, "wrap4");
    burst(0, 3'b010, 2'b10, 13, 8, "wrap8");
    burst(0, 3'b010, 2'b11, 29, 16, "wrap16");
    burst(0, 3'b001, 2'b00, 9, 3, "const");

    // Incrementing read, stb dropped for two cycles after beat 2, then a new access.
    sb_q.push_back(model[8]);
    sb_q.push_back(model[9]);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; cti = 3'b010; bte = 2'b00; adr = 32'(8) << 2;
    step();
    chk("gap beat0 ack", {31'b0, ack}, 32'd1);
    sb_pop("gap beat0 data");
    step();
    adr = 32'(9) << 2;
    chk("gap beat1 ack", {31'b0, ack}, 32'd1);
    sb_pop("gap beat1 data");
    step();
    stb = 0;
    step();
    chk("gap cycle1 ack", {31'b0, ack}, 32'd0);
    step();
    chk("gap cycle2 ack", {31'b0, ack}, 32'd0);
    burst(0, 3'b010, 2'b00, 20, 2, "resume");

    // Out-of-range read and write: err for one cycle, no ack, no write.
    cyc = 1; stb = 1; we = 0; sel = 4'hF; cti = 3'b000; adr = (32'd1 << 13) | (32'd4 << 2);
    step();
    chk("oor rd err", {31'b0, err}, 32'd1);
    chk("oor rd ack", {31'b0, ack}, 32'd0);
    idle_bus();
    step();
    chk("oor rd err drop", {31'b0, err}, 32'd0);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; cti = 3'b000; dat_ms = 32'hBAD0BAD0;
    adr = (32'd1 << 13) | (32'd4 << 2);
    step();
    chk("oor wr err", {31'b0, err}, 32'd1);
    chk("oor wr ack", {31'b0, ack}, 32'd0);
    idle_bus();
    step();
    chk("oor wr err drop", {31'b0, err}, 32'd0);
    sb_q.push_back(model[4]);
    classic(0, 4, 4'hF, 32'h0, "oor unchanged");

    // Reset during a write burst beat: outputs clear at once and the beat is lost.
    cyc = 1; stb = 1; we = 1; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    adr = 32'(30) << 2; dat_ms = 32'h5555AAAA;
    step();
    chk("rstmid beat0 ack", {31'b0, ack}, 32'd1);
    #2 rst = 0;
    #1;
    chk("rstmid ack", {31'b0, ack}, 32'd0);
    chk("rstmid err", {31'b0, err}, 32'd0);
    chk("rstmid dat_sm", dat_sm, 32'd0);
    idle_bus();
    step();
    step();
    rst = 1;
    step();
    sb_q.push_back(model[30]);
    classic(0, 30, 4'hF, 32'h0, "rstmid no write");

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
